hms_timekeeper: RTL and testbench

- Parametrised cascaded time-of-day counter: seconds, minutes and hours fields, each with its own modulus.
- Adds up/down counting, parallel load, synchronous clear, per-field wrap pulses and an alarm comparator.
- Sits under the clock/stopwatch top level and is driven by a 1 Hz tick enable from the prescaler.
- Replaces stand-alone single-field counters in new designs.

---
 rtl/timekeeper_pkg.sv | 33 +++
 rtl/mod_counter.sv | 49 ++++
 rtl/hms_timekeeper.sv | 131 +++++++++++++
 tb/tb_hms_timekeeper.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timekeeper_pkg
// Function : Shared constants and helpers for the hms time-of-day counter.
// Revision : 1.0 - initial release
// ============================================================================
package timekeeper_pkg;

  // Default field moduli for a 24-hour clock.
  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 60;
  localparam int HR_MOD_DEF  = 24;

  // Bits needed to hold 0..m-1.
  function automatic int mod_width(input int m);
    return $clog2(m);
  endfunction

  // Clamp an out-of-range load value to the field maximum.
  function automatic int sat_val(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  // Value a field takes after one enabled count step; holds when not enabled.
  function automatic int step_val(input int cur, input int max_v, input bit wrap,
                                  input bit up, input bit en);
    if (!en)       return cur;
    else if (wrap) return up ? 0 : max_v;
    else           return up ? cur + 1 : cur - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Function : Single modulo-MOD up/down counter field with clear, saturating
//            parallel load and a combinational carry/borrow output.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter
  import timekeeper_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up_dn,
  output logic [W-1:0] count,
  output logic         wrap_comb
);

  localparam logic [W-1:0] c_MAX = W'(MOD - 1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_load_sat;
  logic [W-1:0] w_step;

  assign w_load_sat = W'(sat_val(int'(load_val), MOD - 1));

  // Carry (up) or borrow (down) out of this field; feeds the next field's enable.
  assign wrap_comb = en & (up_dn ? (r_count == c_MAX) : (r_count == '0));

  assign w_step = W'(step_val(int'(r_count), MOD - 1, wrap_comb, up_dn, 1'b1));

  // Field register: clear beats load beats count enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_count <= '0;
    else if (clear) r_count <= '0;
    else if (load)  r_count <= w_load_sat;
    else if (en)    r_count <= w_step;
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hms_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : hms_timekeeper
// Function : Cascaded hours:minutes:seconds counter with up/down count,
//            parallel load, clear, registered wrap pulses and alarm hit.
// Revision : 1.0 - initial release
// ============================================================================
module hms_timekeeper
  import timekeeper_pkg::*;
#(
  parameter  int SEC_MOD = SEC_MOD_DEF,
  parameter  int MIN_MOD = MIN_MOD_DEF,
  parameter  int HR_MOD  = HR_MOD_DEF,
  localparam int SEC_W   = mod_width(SEC_MOD),
  localparam int MIN_W   = mod_width(MIN_MOD),
  localparam int HR_W    = mod_width(HR_MOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  input  logic             up_dn,
  input  logic             load,
  input  logic [HR_W-1:0]  load_hh,
  input  logic [MIN_W-1:0] load_mm,
  input  logic [SEC_W-1:0] load_ss,
  input  logic             alarm_en,
  input  logic [HR_W-1:0]  alarm_hh,
  input  logic [MIN_W-1:0] alarm_mm,
  input  logic [SEC_W-1:0] alarm_ss,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             sec_wrap,
  output logic             min_wrap,
  output logic             day_wrap,
  output logic             alarm_hit
);

  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hr_wrap;

  logic [HR_W-1:0]  w_hh_nxt;
  logic [MIN_W-1:0] w_mm_nxt;
  logic [SEC_W-1:0] w_ss_nxt;
  logic             w_alarm_match;

  logic r_sec_wrap;
  logic r_min_wrap;
  logic r_day_wrap;
  logic r_alarm_hit;

  mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load      (load),
    .load_val  (load_ss),
    .en        (tick),
    .up_dn     (up_dn),
    .count     (seconds),
    .wrap_comb (w_sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load      (load),
    .load_val  (load_mm),
    .en        (w_sec_wrap),
    .up_dn     (up_dn),
    .count     (minutes),
    .wrap_comb (w_min_wrap)
  );

  mod_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load      (load),
    .load_val  (load_hh),
    .en        (w_min_wrap),
    .up_dn     (up_dn),
    .count     (hours),
    .wrap_comb (w_hr_wrap)
  );

  // Predicted time after this edge (clear is excluded later, it never hits).
  always_comb begin
    w_ss_nxt = seconds;
    w_mm_nxt = minutes;
    w_hh_nxt = hours;
    if (load) begin
      w_ss_nxt = SEC_W'(sat_val(int'(load_ss), SEC_MOD - 1));
      w_mm_nxt = MIN_W'(sat_val(int'(load_mm), MIN_MOD - 1));
      w_hh_nxt = HR_W'(sat_val(int'(load_hh), HR_MOD - 1));
    end else begin
      w_ss_nxt = SEC_W'(step_val(int'(seconds), SEC_MOD - 1, w_sec_wrap, up_dn, tick));
      w_mm_nxt = MIN_W'(step_val(int'(minutes), MIN_MOD - 1, w_min_wrap, up_dn, w_sec_wrap));
      w_hh_nxt = HR_W'(step_val(int'(hours), HR_MOD - 1, w_hr_wrap, up_dn, w_min_wrap));
    end
  end

  // Out-of-range alarm fields can never equal an in-range counter value.
  assign w_alarm_match = (w_hh_nxt == alarm_hh) && (w_mm_nxt == alarm_mm) &&
                         (w_ss_nxt == alarm_ss);

  // Event pulses: only real count steps wrap, only tick/load can hit the alarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_wrap  <= 1'b0;
      r_min_wrap  <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_alarm_hit <= 1'b0;
    end else begin
      r_sec_wrap  <= w_sec_wrap & ~clear & ~load;
      r_min_wrap  <= w_min_wrap & ~clear & ~load;
      r_day_wrap  <= w_hr_wrap  & ~clear & ~load;
      r_alarm_hit <= alarm_en & ~clear & (load | tick) & w_alarm_match;
    end
  end

  assign sec_wrap  = r_sec_wrap;
  assign min_wrap  = r_min_wrap;
  assign day_wrap  = r_day_wrap;
  assign alarm_hit = r_alarm_hit;

endmodule
`default_nettype wire

// File: tb/tb_hms_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_hms_timekeeper
// Function : Directed self-checking bench for hms_timekeeper, default moduli
//            plus a 10/6/12 instance for the non-power-of-two cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hms_timekeeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Default-moduli instance (24:60:60 -> widths 5/6/6)
  logic       clear = 0, tick = 0, up_dn = 1, load = 0, alarm_en = 0;
  logic [4:0] load_hh = 0, alarm_hh = 0, hours;
  logic [5:0] load_mm = 0, alarm_mm = 0, minutes;
  logic [5:0] load_ss = 0, alarm_ss = 0, seconds;
  logic       sec_wrap, min_wrap, day_wrap, alarm_hit;

  // Small-moduli instance (12:6:10 -> widths 4/3/4)
  logic       clear2 = 0, tick2 = 0, load2 = 0;
  logic [3:0] hours2;
  logic [2:0] minutes2;
  logic [3:0] seconds2;
  logic       sec_wrap2, min_wrap2, day_wrap2, alarm_hit2;

  int n_total = 0;
  int n_bad   = 0;
  int n_sw = 0, n_mw = 0, n_dw = 0;

  always #5 clk = ~clk;

  hms_timekeeper u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .tick(tick), .up_dn(up_dn),
    .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .sec_wrap(sec_wrap), .min_wrap(min_wrap), .day_wrap(day_wrap), .alarm_hit(alarm_hit)
  );

  hms_timekeeper #(.SEC_MOD(10), .MIN_MOD(6), .HR_MOD(12)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .tick(tick2), .up_dn(1'b1),
    .load(load2), .load_hh(4'd0), .load_mm(3'd0), .load_ss(4'd0),
    .alarm_en(1'b0), .alarm_hh(4'd0), .alarm_mm(3'd0), .alarm_ss(4'd0),
    .hours(hours2), .minutes(minutes2), .seconds(seconds2),
    .sec_wrap(sec_wrap2), .min_wrap(min_wrap2), .day_wrap(day_wrap2), .alarm_hit(alarm_hit2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, then settle past the edge before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tm();
    return hours * 10000 + minutes * 100 + seconds;
  endfunction

  function automatic logic [31:0] pulses();
    return {29'd0, sec_wrap, min_wrap, day_wrap};
  endfunction

  initial begin
    // Reset held for 3 cycles with tick toggling
    tick = 1;
    repeat (3) step();
    check("rst_time", tm(), 0);
    check("rst_pulses", {pulses(), 3'd0, alarm_hit}, 0);
    rst_n = 1; tick = 0;
    repeat (2) step();
    check("idle_time", tm(), 0);
    check("idle_pulses", pulses(), 0);

    // Up cascade through full-day rollover
    load = 1; load_hh = 23; load_mm = 59; load_ss = 58;
    step();
    check("load_235958", tm(), 235958);
    check("load_no_wrap", pulses(), 0);
    load = 0; up_dn = 1; tick = 1;
    step();
    check("up_235959", tm(), 235959);
    check("up_235959_pulses", pulses(), 0);
    step();
    check("up_rollover", tm(), 0);
    check("up_rollover_pulses", pulses(), 7);
    tick = 0;
    step();
    check("after_rollover_pulses", pulses(), 0);
    check("after_rollover_hold", tm(), 0);

    // Down borrow from zero
    clear = 1;
    step();
    clear = 0; up_dn = 0; tick = 1;
    step();
    check("dn_borrow", tm(), 235959);
    check("dn_borrow_pulses", pulses(), 7);
    step();
    check("dn_235958", tm(), 235958);
    check("dn_235958_pulses", pulses(), 0);
    tick = 0;

    // Priority: clear beats load and tick
    clear = 1; load = 1; tick = 1; load_hh = 5; load_mm = 5; load_ss = 5;
    step();
    check("prio_clear", tm(), 0);
    check("prio_clear_pulses", pulses(), 0);
    // Load beats tick, no wrap pulses
    clear = 0; load_hh = 1; load_mm = 2; load_ss = 3;
    step();
    check("prio_load", tm(), 10203);
    tick = 0;
    // Saturation: 63 is the largest minute value that fits the 6-bit port
    load_hh = 30; load_mm = 63; load_ss = 61;
    step();
    check("load_saturate", tm(), 235959);
    load = 0;

    // Alarm at 00:01:00, approached by counting up
    alarm_en = 1; alarm_hh = 0; alarm_mm = 1; alarm_ss = 0; up_dn = 1;
    load = 1; load_hh = 0; load_mm = 0; load_ss = 58;
    step();
    check("alarm_load_nohit", alarm_hit, 0);
    load = 0; tick = 1;
    step();
    check("alarm_59_nohit", alarm_hit, 0);
    step();
    check("alarm_time", tm(), 100);
    check("alarm_hit", alarm_hit, 1);
    tick = 0;
    step();
    check("alarm_stationary1", alarm_hit, 0);
    step();
    check("alarm_stationary2", alarm_hit, 0);
    // Load straight into the alarm time hits
    load = 1; load_hh = 0; load_mm = 1; load_ss = 0;
    step();
    check("alarm_load_hit", alarm_hit, 1);
    load = 0;
    // Clear into an alarm of 00:00:00 never hits
    alarm_mm = 0; clear = 1;
    step();
    check("alarm_clear_nohit", alarm_hit, 0);
    clear = 0;
    // Out-of-range alarm seconds cannot match a saturated load
    alarm_hh = 23; alarm_mm = 59; alarm_ss = 63;
    load = 1; load_hh = 23; load_mm = 59; load_ss = 63;
    step();
    check("alarm_oor_nohit", alarm_hit, 0);
    load = 0;
    // Alarm disabled: reaching the match does not fire
    alarm_en = 0; alarm_ss = 59;
    load = 1;
    step();
    check("alarm_disabled", alarm_hit, 0);
    load = 0;

    // Asynchronous reset mid-count and mid-load
    tick = 1; load = 1; load_hh = 7; load_mm = 7; load_ss = 7;
    #3 rst_n = 0;
    #1 check("async_rst", tm(), 0);
    step();
    check("rst_hold_load", tm(), 0);
    load = 0; tick = 0;
    rst_n = 1;
    step();
    check("rst_release", tm(), 0);

    // Small moduli: one full day of 720 ticks
    tick2 = 1;
    for (int i = 0; i < 720; i++) begin
      step();
      n_sw += int'(sec_wrap2);
      n_mw += int'(min_wrap2);
      n_dw += int'(day_wrap2);
    end
    tick2 = 0;
    check("small_sec_wraps", n_sw, 72);
    check("small_min_wraps", n_mw, 12);
    check("small_day_wraps", n_dw, 1);
    check("small_end_time", {hours2, 1'b0, minutes2, seconds2}, 0);
    step();
    check("small_idle_pulses", {sec_wrap2, min_wrap2, day_wrap2}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
